dest_reg_tracker: RTL and testbench
===================================

// Module: dest_reg_tracker
// PURPOSE
//  ID-stage hazard tracker that sits directly upstream of the forwarding unit.
//  Keeps a registered history of the destination registers of the two instructions ahead of ID, in EX and MEM.
//  Drives RD_imm_old (EX) and RD_old_old (MEM) to the forwarding unit.
//  Detects load-use hazards and stalls IF/ID, inserting a bubble into EX.
// PARAMETERS
//  REG_AW        5   register-address width
//  DIV_LATENCY   8   EX-occupancy cycles of DIV/DIVU/REM/REMU; used only with MULDIV_STALL_EN
// PORTS
//  CLK             in   1   pipeline clock, rising edge
//  RESET           in   1   asynchronous, active-high reset
//  ID_INSTRUCTION  in   32  instruction currently in ID
//  ID_VALID        in   1   ID holds a real instruction; 0 means a bubble
//  FLUSH           in   1   taken branch/jump resolved in EX; squash the ID instruction
//  STALL           out  1   hold PC and the IF/ID register this cycle
//  BUBBLE          out  1   load a NOP into ID/EX this cycle
//  RD_imm_old      out  5   rd of the instruction in EX; 0 if it does not write a register
//  RD_old_old      out  5   rd of the instruction in MEM; 0 if it does not write a register
//  WB_imm_old      out  1   instruction in EX writes a nonzero rd
//  WB_old_old      out  1   instruction in MEM writes a nonzero rd
// BEHAVIOUR
//  Reset: all outputs 0, both history slots empty (rd=0, wb=0, ld=0), FSM in IDLE, counter 0.
//  Decode of ID_INSTRUCTION (combinational):
//   - wb=1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and only if rd!=0.
//   - ld=1 for opcode 0000011.
//   - rs1 is used by 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
//   - rs2 is used by 0110011, 0100011, 1100011.
//   - Any instruction with ID_VALID=0 is an empty slot.
//  Load-use hazard (comb.): EX slot ld=1, wb=1, and a used rs of the ID instruction equals the EX rd. x0 never matches.
//  FSM states: IDLE, LOAD_STALL, DIV_BUSY (DIV_BUSY exists only with the macro).
//   - IDLE with a hazard and FLUSH=0: STALL=1 and BUBBLE=1, combinationally in the same cycle. Next state LOAD_STALL.
//   - LOAD_STALL: STALL=0, BUBBLE=0. The load is now in MEM and forwarded from there. Next state IDLE.
//     No re-detection is possible because the EX slot now holds the bubble.
//  History shift (every rising edge):
//   - MEM slot <= EX slot.
//   - EX slot <= decoded ID instruction, or an empty slot if BUBBLE=1, FLUSH=1 or ID_VALID=0.
//  RD_*/WB_* outputs are driven directly from the slot registers, so they update one cycle after ID.
//  FLUSH has priority over hazard detection: no stall is raised and an empty slot enters EX. FLUSH in LOAD_STALL leaves the next state as IDLE.
//  Both source registers hitting the same load produce one stall, not two.
//  Asserting RESET mid-stall returns to IDLE immediately with no residual STALL.
// CONFIGURATION
//  MULDIV_STALL_EN defined:
//   - An ID instruction with opcode 0110011, funct7 0000001 and funct3[2]=1 (a divide) enters EX normally.
//   - On the next cycle the FSM moves to DIV_BUSY with counter = DIV_LATENCY-1.
//   - While in DIV_BUSY: STALL=1 and BUBBLE=0. The EX slot holds, the MEM slot receives empty slots, and the counter decrements.
//   - When the counter reaches 0: STALL=0 and the state goes to IDLE.
//   - FLUSH is ignored while in DIV_BUSY.
//  MULDIV_STALL_EN undefined: divides are single-cycle and treated like any R-type; DIV_BUSY and the counter are absent.
// STRUCTURE
//  rv32_pkg holds:
//   - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, FUNCT7_MULDIV);
//   - typedef trk_state_t {IDLE, LOAD_STALL, DIV_BUSY};
//   - typedef slot_t {rd, wb, ld}.
//  One sub-module, rd_decode: combinational instruction -> {rd, wb, ld, use_rs1, use_rs2, is_div}.
//  Hazard compare, FSM and history registers stay in dest_reg_tracker.
// TESTING
//  1. add x5,x1,x2 then sub x6,x5,x3 -> no STALL. Cycle after sub in ID: RD_imm_old=6, RD_old_old=5.
//  2. lw x7,0(x1) then add x8,x7,x7 -> STALL=1, BUBBLE=1 for exactly 1 cycle. Next cycle: RD_imm_old=0, RD_old_old=7.
//  3. lw x0,0(x1) then add x8,x0,x0; also lw x7 then sw x9,0(x2) -> no STALL in either case.
//     (x0 never matches; sw x9,0(x2) uses rs1=x2, rs2=x9, neither equal to x7.)
//  4. lw x7 then beq x7,x0 with FLUSH=1 in the same cycle -> STALL=0, the EX slot becomes empty.
//     Also sw x1,0(x2) -> WB_imm_old=0, RD_imm_old=0.
//  5. RESET asserted during LOAD_STALL -> all outputs 0 asynchronously. After release: IDLE, both slots empty.
//  6. MULDIV_STALL_EN, DIV_LATENCY=8: div x4,x1,x2 -> STALL high for 8 consecutive cycles and RD_imm_old=4 throughout.
//     RD_old_old=0 from the second stalled cycle. FLUSH pulsed mid-divide is ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and tracker types.
// MULDIV_STALL_EN adds the DIV_BUSY state for multi-cycle divides.
package rv32_pkg;

    localparam int RD_W = 5;

    localparam logic [6:0] OP_R          = 7'b0110011;
    localparam logic [6:0] OP_IMM        = 7'b0010011;
    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_STORE      = 7'b0100011;
    localparam logic [6:0] OP_BRANCH     = 7'b1100011;
    localparam logic [6:0] OP_LUI        = 7'b0110111;
    localparam logic [6:0] OP_AUIPC      = 7'b0010111;
    localparam logic [6:0] OP_JAL        = 7'b1101111;
    localparam logic [6:0] OP_JALR       = 7'b1100111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
`ifdef MULDIV_STALL_EN
        DIV_BUSY   = 2'd2,
`endif
        LOAD_STALL = 2'd1
    } trk_state_t;

    // One pipeline-slot history entry; rd is already zeroed when wb=0
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            wb;
        logic            ld;
    } slot_t;

    // Opcodes whose result lands in the register file
    function automatic logic op_writes_rd(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/dest_reg_tracker_if.sv
// ID-stage bundle between the pipeline front end and the hazard tracker.
interface dest_reg_tracker_if #(
    parameter int REG_AW = 5
);
    logic [31:0]       ID_INSTRUCTION;
    logic              ID_VALID;
    logic              FLUSH;
    logic              STALL;
    logic              BUBBLE;
    logic [REG_AW-1:0] RD_imm_old;
    logic [REG_AW-1:0] RD_old_old;
    logic              WB_imm_old;
    logic              WB_old_old;

    modport master (
        output ID_INSTRUCTION, ID_VALID, FLUSH,
        input  STALL, BUBBLE, RD_imm_old, RD_old_old, WB_imm_old, WB_old_old
    );

    modport slave (
        input  ID_INSTRUCTION, ID_VALID, FLUSH,
        output STALL, BUBBLE, RD_imm_old, RD_old_old, WB_imm_old, WB_old_old
    );
endinterface

// File: rtl/rd_decode.sv
// Combinational decode of the ID instruction into the fields the
// hazard tracker needs. An invalid slot decodes to all zeros.
module rd_decode
    import rv32_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic            valid,
    output logic [RD_W-1:0] rd,
    output logic [RD_W-1:0] rs1,
    output logic [RD_W-1:0] rs2,
    output logic            wb,
    output logic            ld,
    output logic            use_rs1,
    output logic            use_rs2,
    output logic            is_div
);
    logic [6:0] op;
    logic       unused_funct3_lo;

    assign op               = instr[6:0];
    assign unused_funct3_lo = ^instr[13:12];

    // Field extraction and per-opcode register usage
    always_comb begin
        wb      = valid && op_writes_rd(op) && (instr[11:7] != '0);
        rd      = wb ? instr[11:7] : '0;
        ld      = valid && (op == OP_LOAD);
        rs1     = instr[19:15];
        rs2     = instr[24:20];
        use_rs1 = valid && (op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR});
        use_rs2 = valid && (op inside {OP_R, OP_STORE, OP_BRANCH});
        is_div  = valid && (op == OP_R) && (instr[31:25] == FUNCT7_MULDIV) && instr[14];
    end
endmodule

// File: rtl/dest_reg_tracker.sv
// ID-stage destination-register history and load-use stall generator.
// Optional: define MULDIV_STALL_EN to hold EX for DIV_LATENCY cycles on divides.
module dest_reg_tracker
    import rv32_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DIV_LATENCY = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    dest_reg_tracker_if.slave  bus
);
    logic [RD_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic            dec_wb, dec_ld, dec_use_rs1, dec_use_rs2, dec_is_div;
    slot_t           dec_slot;

    slot_t           ex_q, ex_d, mem_q, mem_d;
    trk_state_t      state_q, state_d;
    logic            hazard, stall, bubble, hold_ex;

    rd_decode u_dec (
        .instr   (bus.ID_INSTRUCTION),
        .valid   (bus.ID_VALID),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .wb      (dec_wb),
        .ld      (dec_ld),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .is_div  (dec_is_div)
    );

    assign dec_slot = '{rd: dec_rd, wb: dec_wb, ld: dec_ld};

`ifdef MULDIV_STALL_EN
    localparam int CNT_W = $clog2(DIV_LATENCY + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_div_latency = DIV_LATENCY;
    logic unused_is_div;
    assign unused_is_div = dec_is_div;
`endif

    // Load-use compare: ex_q.wb already implies rd!=0, so x0 never matches
    always_comb begin
        hazard = ex_q.ld && ex_q.wb &&
                 ((dec_use_rs1 && (dec_rs1 == ex_q.rd)) ||
                  (dec_use_rs2 && (dec_rs2 == ex_q.rd)));
    end

    // FSM, stall/bubble generation and next history contents
    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        hold_ex = 1'b0;
        state_d = state_q;
        ex_d    = dec_slot;
        mem_d   = ex_q;
`ifdef MULDIV_STALL_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hazard && !bus.FLUSH) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = LOAD_STALL;
                end
            end
            LOAD_STALL: state_d = IDLE;
`ifdef MULDIV_STALL_EN
            // Divide occupies EX; FLUSH is deliberately ignored here
            DIV_BUSY: begin
                stall   = 1'b1;
                hold_ex = 1'b1;
                ex_d    = ex_q;
                mem_d   = '0;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (!hold_ex && (bubble || bus.FLUSH || !bus.ID_VALID))
            ex_d = '0;

`ifdef MULDIV_STALL_EN
        // A divide entering EX arms the busy window for the following cycles
        if (!hold_ex && dec_is_div && !bubble && !bus.FLUSH) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_W'(DIV_LATENCY - 1);
        end
`endif
    end

    // History slots and FSM state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_q    <= '0;
            mem_q   <= '0;
            state_q <= IDLE;
`ifdef MULDIV_STALL_EN
            cnt_q   <= '0;
`endif
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            state_q <= state_d;
`ifdef MULDIV_STALL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.STALL      = stall;
    assign bus.BUBBLE     = bubble;
    assign bus.RD_imm_old = REG_AW'(ex_q.rd);
    assign bus.RD_old_old = REG_AW'(mem_q.rd);
    assign bus.WB_imm_old = ex_q.wb;
    assign bus.WB_old_old = mem_q.wb;
endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench for dest_reg_tracker: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_dest_reg_tracker;
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    dest_reg_tracker_if #(.REG_AW(5)) bus();

    dest_reg_tracker #(.REG_AW(5), .DIV_LATENCY(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    localparam logic [6:0]  R  = 7'b0110011;
    localparam logic [31:0] NOP        = 32'h0;
    localparam logic [31:0] ADD_5_1_2  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, R};
    localparam logic [31:0] SUB_6_5_3  = {7'b0100000, 5'd3, 5'd5, 3'b000, 5'd6, R};
    localparam logic [31:0] LW_7_1     = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] LW_0_1     = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_8_7_7  = {7'b0000000, 5'd7, 5'd7, 3'b000, 5'd8, R};
    localparam logic [31:0] ADD_8_0_0  = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd8, R};
    localparam logic [31:0] ADD_8_7_2  = {7'b0000000, 5'd2, 5'd7, 3'b000, 5'd8, R};
    localparam logic [31:0] SW_9_2     = {7'd0, 5'd9, 5'd2, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] BEQ_7_0    = {7'd0, 5'd0, 5'd7, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] DIV_4_1_2  = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd4, R};

    typedef struct {
        int          cyc;
        string       name;
        logic [13:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    // {STALL, BUBBLE, RD_imm_old, RD_old_old, WB_imm_old, WB_old_old}
    function automatic logic [13:0] outs();
        return {bus.STALL, bus.BUBBLE, bus.RD_imm_old, bus.RD_old_old, bus.WB_imm_old, bus.WB_old_old};
    endfunction

    function automatic logic [13:0] E(input logic s, input logic b, input logic [4:0] re,
                                      input logic [4:0] rm, input logic we, input logic wm);
        return {s, b, re, rm, we, wm};
    endfunction

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got stall=%b bubble=%b rd_ex=%0d rd_mem=%0d wb_ex=%b wb_mem=%b, want stall=%b bubble=%b rd_ex=%0d rd_mem=%0d wb_ex=%b wb_mem=%b",
                     name, got[13], got[12], got[11:7], got[6:2], got[1], got[0],
                     exp[13], exp[12], exp[11:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    // Drive one ID cycle and queue what the outputs must read during it
    task automatic step(input string name, input logic [31:0] ins, input logic v,
                        input logic f, input logic [13:0] e);
        exp_t x;
        @(posedge CLK);
        #1;
        bus.ID_INSTRUCTION = ins;
        bus.ID_VALID       = v;
        bus.FLUSH          = f;
        x.cyc  = cyc;
        x.name = name;
        x.exp  = e;
        q.push_back(x);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare the expectation queued for this cycle
    always @(negedge CLK) begin
        exp_t x;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            x = q.pop_front();
            chk(x.name, outs(), x.exp);
        end
    end

    initial begin
        bus.ID_INSTRUCTION = NOP;
        bus.ID_VALID       = 1'b0;
        bus.FLUSH          = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_state", outs(), '0);
        RESET = 1'b0;

        // add -> dependent sub: plain forwarding, no stall
        step("t1_add",       ADD_5_1_2, 1'b1, 1'b0, E(0, 0, 5'd0, 5'd0, 0, 0));
        step("t1_sub",       SUB_6_5_3, 1'b1, 1'b0, E(0, 0, 5'd5, 5'd0, 1, 0));
        step("t1_after_sub", NOP,       1'b0, 1'b0, E(0, 0, 5'd6, 5'd5, 1, 1));
        // lw x7 -> add x8,x7,x7: one stall+bubble even with both sources hitting
        step("t2_lw",        LW_7_1,    1'b1, 1'b0, E(0, 0, 5'd0, 5'd6, 0, 1));
        step("t2_stall",     ADD_8_7_7, 1'b1, 1'b0, E(1, 1, 5'd7, 5'd0, 1, 0));
        step("t2_released",  ADD_8_7_7, 1'b1, 1'b0, E(0, 0, 5'd0, 5'd7, 0, 1));
        // x0 load target never matches
        step("t3_lw_x0",     LW_0_1,    1'b1, 1'b0, E(0, 0, 5'd8, 5'd0, 1, 0));
        step("t3_add_x0",    ADD_8_0_0, 1'b1, 1'b0, E(0, 0, 5'd0, 5'd8, 0, 1));
        // lw x7 -> sw x9,0(x2): no source match
        step("t3_lw_x7",     LW_7_1,    1'b1, 1'b0, E(0, 0, 5'd8, 5'd0, 1, 0));
        step("t3_sw",        SW_9_2,    1'b1, 1'b0, E(0, 0, 5'd7, 5'd8, 1, 1));
        // store in EX writes nothing; then FLUSH beats a real hazard
        step("t4_sw_in_ex",  LW_7_1,    1'b1, 1'b0, E(0, 0, 5'd0, 5'd7, 0, 1));
        step("t4_flush",     BEQ_7_0,   1'b1, 1'b1, E(0, 0, 5'd7, 5'd0, 1, 0));
        step("t4_ex_empty",  NOP,       1'b0, 1'b0, E(0, 0, 5'd0, 5'd7, 0, 1));
        // reset asserted in the middle of a load stall
        step("t5_lw",        LW_7_1,    1'b1, 1'b0, E(0, 0, 5'd0, 5'd0, 0, 0));
        step("t5_stall",     ADD_8_7_2, 1'b1, 1'b0, E(1, 1, 5'd7, 5'd0, 1, 0));
        @(negedge CLK);
        #1;
        RESET        = 1'b1;
        bus.ID_VALID = 1'b0;
        #1;
        chk("t5_async_reset", outs(), '0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        step("t5_idle_empty", ADD_8_7_2, 1'b1, 1'b0, E(0, 0, 5'd0, 5'd0, 0, 0));
        step("t5_add_in_ex",  NOP,       1'b0, 1'b0, E(0, 0, 5'd8, 5'd0, 1, 0));
        step("t6_div_in_id",  DIV_4_1_2, 1'b1, 1'b0, E(0, 0, 5'd0, 5'd8, 0, 1));
`ifdef MULDIV_STALL_EN
        for (int i = 0; i < 8; i++)
            step($sformatf("t6_div_busy%0d", i), NOP, 1'b0, (i == 3), E(1, 0, 5'd4, 5'd0, 1, 0));
        step("t6_div_done",   NOP, 1'b0, 1'b0, E(0, 0, 5'd4, 5'd0, 1, 0));
        step("t6_div_in_mem", NOP, 1'b0, 1'b0, E(0, 0, 5'd0, 5'd4, 0, 1));
`else
        step("t6_div_single", NOP, 1'b0, 1'b0, E(0, 0, 5'd4, 5'd0, 1, 0));
        step("t6_div_in_mem", NOP, 1'b0, 1'b0, E(0, 0, 5'd0, 5'd4, 0, 1));
`endif
        @(negedge CLK);
        @(negedge CLK);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
